chirp_cmd_ctrl: RTL and testbench
=================================

CHIRP_CMD_CTRL -- requirements
Module: chirp_cmd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, chirp register-file address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, register and UART byte width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 20000, inter-byte timeout in clocks (2 ms at 10 MHz); max 65535.
REQ-004 SHALL use one clock; reset is synchronous and active-low. Ports: i_clk input 1 (rising-edge clock, 10 MHz); i_rst_n input 1 (synchronous active-low reset).
REQ-005 SHALL have i_rx_valid input 1: one-cycle strobe, UART RX byte available.
REQ-006 SHALL have i_rx_data input 8: received byte, valid with i_rx_valid.
REQ-007 SHALL have i_done_n input 1: chirp generator done, active low.
REQ-008 SHALL have i_rsp_ready input 1: UART TX can accept response byte.
REQ-009 SHALL have outputs o_wr_en 1 (register write strobe), o_wr_addr ADDR_WIDTH, o_wr_data DATA_WIDTH.
REQ-010 SHALL have outputs o_start 1 (one-cycle chirp start), o_busy 1 (chirp in progress), o_err 1 (one-cycle frame error pulse).
REQ-011 SHALL have outputs o_rsp_valid 1 and o_rsp_data 8 (response byte to UART TX).

Function
REQ-012 SHALL parse frames SYNC(0xA5), CMD, ADDR, DATA, CHK; CHK = CMD^ADDR^DATA.
REQ-013 SHALL implement FSM states IDLE, CMD, ADDR, DATA, CHK, EXEC, RESP; each accepted byte advances one state; IDLE advances only on 0xA5, other bytes discarded silently.
REQ-014 SHALL leave EXEC after exactly one cycle, always to RESP.
REQ-015 SHALL, for CHK byte accepted in cycle N, assert o_wr_en or o_start (if applicable) and o_rsp_valid with o_rsp_data in cycle N+1.
REQ-016 SHALL define responses: ACK 0x06, NAK 0x15 (bad checksum, unknown CMD, ADDR bits [7:ADDR_WIDTH] nonzero), BUSY 0x42.
REQ-017 SHALL, for CMD 0x01 (write) with valid frame and o_busy low, pulse o_wr_en one cycle with o_wr_addr=ADDR[ADDR_WIDTH-1:0], o_wr_data=DATA, respond ACK.
REQ-018 SHALL, for CMD 0x02 (start) with valid frame and o_busy low, pulse o_start one cycle, set o_busy next cycle, respond ACK; ADDR/DATA ignored but included in checksum.
REQ-019 SHALL, for valid CMD 0x01/0x02 while o_busy high, respond BUSY with no o_wr_en/o_start.
REQ-020 SHALL give NAK priority over BUSY; NAK pulses o_err one cycle in EXEC.
REQ-021 SHALL hold o_rsp_valid and o_rsp_data stable in RESP until i_rsp_ready high; on that cycle return to IDLE, o_rsp_valid low next cycle.
REQ-022 SHALL drop bytes received in EXEC or RESP.
REQ-023 SHALL clear o_busy on first cycle i_done_n sampled low while o_busy high; i_done_n low in the o_start cycle is ignored.
REQ-024 SHALL run 16-bit timeout counter in CMD..CHK, cleared on each accepted byte; at TIMEOUT_CYC-1 without a byte, go to IDLE, pulse o_err, no response.
REQ-025 SHALL keep o_wr_en, o_start, o_err, o_rsp_valid low outside the cases above; o_wr_addr/o_wr_data hold last written values.
REQ-026 SHALL leave o_busy unaffected by frame errors, timeouts and RESP stalls.

Reset
REQ-027 SHALL, when i_rst_n low at a rising edge, set FSM=IDLE, all outputs 0, timeout counter 0, frame registers 0, regardless of state (including mid-frame, RESP, busy).
REQ-028 SHALL accept a new SYNC in the first cycle after i_rst_n returns high.

Verification
REQ-029 SHALL verify write: A5 01 03 55 57, i_rsp_ready=1 -> o_wr_en 1 cycle, addr 3, data 0x55, rsp 0x06.
REQ-030 SHALL verify start/done: A5 02 00 00 02 -> o_start pulse, o_busy=1, rsp 06; i_done_n low 1 cycle -> o_busy=0 next cycle.
REQ-031 SHALL verify busy/NAK: while busy, A5 01 03 55 57 -> rsp 0x42, no o_wr_en; A5 01 03 55 00 -> rsp 0x15, o_err pulse; A5 01 40 00 41 -> rsp 0x15.
REQ-032 SHALL verify timeout: A5 01 then 20000 idle cycles -> o_err pulse, no rsp; next A5 01 03 55 57 -> ACK.
REQ-033 SHALL verify backpressure: i_rsp_ready low 50 cycles with bytes arriving -> o_rsp_data stable, bytes dropped, IDLE after ready.
REQ-034 SHALL verify reset mid-frame (after A5 01 03) and while busy -> all outputs 0; following full frame processed normally.

Source files
------------

// File: rtl/chirp_cmd_ctrl.sv
// chirp_cmd_ctrl: UART command-frame parser for the chirp generator.
// Accepts frames A5, CMD, ADDR, DATA, CHK (CHK = CMD^ADDR^DATA), then performs
// a register write or a chirp start and returns a one-byte response
// (ACK / NAK / BUSY). Only bytes that arrive in CMD..CHK are timed for timeout.
module chirp_cmd_ctrl #(
    parameter int ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rx_valid,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_done_n,
    input  logic                  i_rsp_ready,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_start,
    output logic                  o_busy,
    output logic                  o_err,
    output logic                  o_rsp_valid,
    output logic [7:0]            o_rsp_data
);

    localparam logic [7:0]  SYNC_BYTE    = 8'hA5;
    localparam logic [7:0]  CMD_WRITE    = 8'h01;
    localparam logic [7:0]  CMD_START    = 8'h02;
    localparam logic [7:0]  RSP_ACK      = 8'h06;
    localparam logic [7:0]  RSP_NAK      = 8'h15;
    localparam logic [7:0]  RSP_BUSY     = 8'h42;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_CHK,
        ST_EXEC,
        ST_RESP
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [7:0]  cmd_reg;
    logic [7:0]  addr_reg;
    logic [7:0]  data_reg;
    logic [15:0] tmo_cnt_reg;

    logic        in_frame;
    logic        timeout_hit;
    logic        chk_accept;
    logic        chk_ok;
    logic        cmd_known;
    logic        addr_ok;
    logic        frame_bad;
    logic        do_write;
    logic        do_start;
    logic [7:0]  rsp_code;

    // Frame decode: the verdict is formed in the cycle the CHK byte arrives so
    // every action and the response can be registered onto the next cycle.
    always_comb begin
        in_frame    = (state_reg == ST_CMD) || (state_reg == ST_ADDR) ||
                      (state_reg == ST_DATA) || (state_reg == ST_CHK);
        timeout_hit = in_frame && !i_rx_valid && (tmo_cnt_reg == TIMEOUT_LAST);
        chk_accept  = (state_reg == ST_CHK) && i_rx_valid;
        chk_ok      = (i_rx_data == (cmd_reg ^ addr_reg ^ data_reg));
        cmd_known   = (cmd_reg == CMD_WRITE) || (cmd_reg == CMD_START);
        addr_ok     = ((addr_reg >> ADDR_WIDTH) == 8'd0);
        // NAK outranks BUSY: a malformed frame is rejected even while busy
        frame_bad   = !chk_ok || !cmd_known || !addr_ok;
        do_write    = chk_accept && !frame_bad && !o_busy && (cmd_reg == CMD_WRITE);
        do_start    = chk_accept && !frame_bad && !o_busy && (cmd_reg == CMD_START);
        if (frame_bad) begin
            rsp_code = RSP_NAK;
        end else if (o_busy) begin
            rsp_code = RSP_BUSY;
        end else begin
            rsp_code = RSP_ACK;
        end
    end

    // Next-state logic: one state per accepted byte, EXEC lasts one cycle,
    // RESP waits for the TX side; bytes seen in EXEC/RESP are simply ignored.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
                    state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                if (i_rx_valid) begin
                    state_next = ST_ADDR;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (i_rx_valid) begin
                    state_next = ST_DATA;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (i_rx_valid) begin
                    state_next = ST_CHK;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end
            end
            ST_CHK: begin
                if (i_rx_valid) begin
                    state_next = ST_EXEC;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Capture CMD, ADDR and DATA bytes as they are accepted
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cmd_reg  <= 8'd0;
            addr_reg <= 8'd0;
            data_reg <= 8'd0;
        end else if (i_rx_valid) begin
            if (state_reg == ST_CMD) begin
                cmd_reg <= i_rx_data;
            end
            if (state_reg == ST_ADDR) begin
                addr_reg <= i_rx_data;
            end
            if (state_reg == ST_DATA) begin
                data_reg <= i_rx_data;
            end
        end
    end

    // Inter-byte timeout: counts idle cycles inside a frame, restarts on each byte
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tmo_cnt_reg <= 16'd0;
        end else if (!in_frame || i_rx_valid || timeout_hit) begin
            tmo_cnt_reg <= 16'd0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
        end
    end

    // Registered strobes, write port and response handshake
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_wr_en     <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_start     <= 1'b0;
            o_err       <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= 8'd0;
        end else begin
            o_wr_en <= do_write;
            o_start <= do_start;
            o_err   <= (chk_accept && frame_bad) || timeout_hit;
            if (do_write) begin
                o_wr_addr <= addr_reg[ADDR_WIDTH-1:0];
                o_wr_data <= DATA_WIDTH'(data_reg);
            end
            if (chk_accept) begin
                o_rsp_valid <= 1'b1;
                o_rsp_data  <= rsp_code;
            end else if ((state_reg == ST_RESP) && i_rsp_ready) begin
                o_rsp_valid <= 1'b0;
            end
        end
    end

    // Busy flag: set the cycle after the start pulse, cleared by done; since the
    // flag is still low during the start cycle, a done seen then is ignored
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_busy <= 1'b0;
        end else if (o_start) begin
            o_busy <= 1'b1;
        end else if (o_busy && !i_done_n) begin
            o_busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_chirp_cmd_ctrl.sv
// tb_chirp_cmd_ctrl: scoreboard bench for chirp_cmd_ctrl. Expected response
// bytes are queued as each CHK byte is driven and compared when the DUT raises
// o_rsp_valid; strobes are counted by a negedge monitor.
module tb_chirp_cmd_ctrl;

    localparam int AW  = 6;
    localparam int DW  = 8;
    localparam int TMO = 20000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          done_n = 1'b1;
    logic          rsp_ready = 1'b1;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          busy;
    logic          err;
    logic          rsp_valid;
    logic [7:0]    rsp_data;

    chirp_cmd_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx_valid (rx_valid),
        .i_rx_data  (rx_data),
        .i_done_n   (done_n),
        .i_rsp_ready(rsp_ready),
        .o_wr_en    (wr_en),
        .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data),
        .o_start    (start),
        .o_busy     (busy),
        .o_err      (err),
        .o_rsp_valid(rsp_valid),
        .o_rsp_data (rsp_data)
    );

    always #50 clk = ~clk;

    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         last_acc_cyc = 0;
    int         rsp_cnt = 0;
    int         wr_cnt = 0;
    int         start_cnt = 0;
    int         err_cnt = 0;
    int         rise_cyc = 0;
    int         err_cyc = 0;
    logic       wr_at_rsp = 1'b0;
    logic       start_at_rsp = 1'b0;
    logic       err_at_rsp = 1'b0;
    logic       rsp_valid_q = 1'b0;
    logic [7:0] rsp_data_q = 8'd0;
    logic [7:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor, sampled on the falling edge
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            rsp_valid_q = 1'b0;
            rsp_data_q  = 8'd0;
        end else begin
            if (wr_en) wr_cnt++;
            if (start) start_cnt++;
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (rsp_valid && !rsp_valid_q) begin
                rsp_cnt++;
                rise_cyc     = cyc;
                wr_at_rsp    = wr_en;
                start_at_rsp = start;
                err_at_rsp   = err;
                if (exp_q.size() == 0) begin
                    check_eq("rsp_unexpected", exp_q.size(), 1);
                end else begin
                    check_eq("rsp_data", rsp_data, exp_q.pop_front());
                end
            end else if (rsp_valid) begin
                check_eq("rsp_stable", rsp_data, rsp_data_q);
            end
            rsp_valid_q = rsp_valid;
            rsp_data_q  = rsp_data;
        end
    end

    // Global time bound
    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid     = 1'b1;
        rx_data      = b;
        last_acc_cyc = cyc;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] k, input logic [7:0] exp_rsp);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(a);
        send_byte(d);
        exp_q.push_back(exp_rsp);
        send_byte(k);
    endtask

    task automatic run_frame(input string name, input logic [7:0] c, input logic [7:0] a,
                             input logic [7:0] d, input logic [7:0] k, input logic [7:0] exp_rsp,
                             input int exp_wr, input int exp_st, input int exp_er);
        int wr0;
        int st0;
        int er0;
        int r0;
        int n;
        wr0 = wr_cnt;
        st0 = start_cnt;
        er0 = err_cnt;
        r0  = rsp_cnt;
        send_frame(c, a, d, k, exp_rsp);
        n = 0;
        while (rsp_cnt == r0 && n < 20) begin
            tick();
            n++;
        end
        check_eq({name, "_rsp_count"}, rsp_cnt, r0 + 1);
        check_eq({name, "_latency"}, rise_cyc - last_acc_cyc, 1);
        n = 0;
        while (rsp_valid && n < 100) begin
            tick();
            n++;
        end
        check_eq({name, "_rsp_release"}, rsp_valid, 0);
        tick();
        tick();
        check_eq({name, "_wr_pulses"}, wr_cnt - wr0, exp_wr);
        check_eq({name, "_start_pulses"}, start_cnt - st0, exp_st);
        check_eq({name, "_err_pulses"}, err_cnt - er0, exp_er);
        check_eq({name, "_pulse_align"}, {wr_at_rsp, start_at_rsp, err_at_rsp},
                 {exp_wr != 0, exp_st != 0, exp_er != 0});
    endtask

    task automatic check_reset_outputs(input string name);
        check_eq({name, "_wr_en"}, wr_en, 0);
        check_eq({name, "_wr_addr"}, wr_addr, 0);
        check_eq({name, "_wr_data"}, wr_data, 0);
        check_eq({name, "_start"}, start, 0);
        check_eq({name, "_busy"}, busy, 0);
        check_eq({name, "_err"}, err, 0);
        check_eq({name, "_rsp_valid"}, rsp_valid, 0);
        check_eq({name, "_rsp_data"}, rsp_data, 0);
    endtask

    initial begin
        int         n;
        int         wr0;
        int         st0;
        int         er0;
        int         r0;
        int         t0;
        logic [7:0] stall_bytes [5];

        stall_bytes[0] = 8'hA5;
        stall_bytes[1] = 8'h01;
        stall_bytes[2] = 8'h03;
        stall_bytes[3] = 8'h55;
        stall_bytes[4] = 8'h57;

        // Power-on reset
        rst_n = 1'b0;
        tick();
        tick();
        tick();
        check_reset_outputs("por");
        rst_n = 1'b1;
        tick();

        // Junk bytes in IDLE are discarded, then a plain write
        send_byte(8'h01);
        send_byte(8'h57);
        run_frame("write", 8'h01, 8'h03, 8'h55, 8'h57, 8'h06, 1, 0, 0);
        check_eq("write_addr", wr_addr, 3);
        check_eq("write_data", wr_data, 8'h55);
        check_eq("write_busy", busy, 0);

        // Start with done_n low only during the start cycle: must be ignored
        st0 = start_cnt;
        r0  = rsp_cnt;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h00);
        exp_q.push_back(8'h06);
        rx_valid     = 1'b1;
        rx_data      = 8'h02;
        last_acc_cyc = cyc;
        tick();
        rx_valid = 1'b0;
        check_eq("start_pulse_now", start, 1);
        check_eq("start_busy_not_yet", busy, 0);
        done_n = 1'b0;
        tick();
        done_n = 1'b1;
        check_eq("start_busy_set", busy, 1);
        tick();
        tick();
        check_eq("start_busy_held", busy, 1);
        check_eq("start_pulses", start_cnt - st0, 1);
        check_eq("start_rsp_count", rsp_cnt, r0 + 1);
        check_eq("start_rsp_idle", rsp_valid, 0);

        // Frames while busy: BUSY for valid commands, NAK outranks BUSY
        run_frame("busy_wr", 8'h01, 8'h03, 8'h55, 8'h57, 8'h42, 0, 0, 0);
        check_eq("busy_wr_addr_hold", wr_addr, 3);
        check_eq("busy_wr_data_hold", wr_data, 8'h55);
        run_frame("busy_start", 8'h02, 8'h00, 8'h00, 8'h02, 8'h42, 0, 0, 0);
        run_frame("nak_chk", 8'h01, 8'h03, 8'h55, 8'h00, 8'h15, 0, 0, 1);
        run_frame("nak_addr", 8'h01, 8'h40, 8'h00, 8'h41, 8'h15, 0, 0, 1);
        run_frame("nak_cmd", 8'h03, 8'h00, 8'h00, 8'h03, 8'h15, 0, 0, 1);
        check_eq("busy_after_errors", busy, 1);

        // Done pulse clears busy on the next cycle
        done_n = 1'b0;
        tick();
        done_n = 1'b1;
        check_eq("done_clears_busy", busy, 0);

        // Inter-byte timeout after A5 01
        er0 = err_cnt;
        r0  = rsp_cnt;
        send_byte(8'hA5);
        send_byte(8'h01);
        t0 = last_acc_cyc;
        n  = 0;
        while (err_cnt == er0 && n < TMO + 100) begin
            tick();
            n++;
        end
        check_eq("tmo_err_pulse", err_cnt - er0, 1);
        check_eq("tmo_window", ((err_cyc - t0) >= TMO - 5) && ((err_cyc - t0) <= TMO + 5), 1);
        tick();
        tick();
        check_eq("tmo_err_single", err_cnt - er0, 1);
        check_eq("tmo_no_rsp", rsp_cnt, r0);
        run_frame("after_tmo", 8'h01, 8'h03, 8'h55, 8'h57, 8'h06, 1, 0, 0);

        // Backpressure: response held 50 cycles while bytes keep arriving
        rsp_ready = 1'b0;
        wr0 = wr_cnt;
        r0  = rsp_cnt;
        send_frame(8'h01, 8'h05, 8'hAA, 8'hAE, 8'h06);
        for (int i = 0; i < 25; i++) begin
            send_byte(stall_bytes[i % 5]);
        end
        check_eq("bp_valid_held", rsp_valid, 1);
        check_eq("bp_data_held", rsp_data, 8'h06);
        check_eq("bp_rsp_count", rsp_cnt, r0 + 1);
        check_eq("bp_wr_pulses", wr_cnt - wr0, 1);
        check_eq("bp_wr_addr", wr_addr, 5);
        check_eq("bp_wr_data", wr_data, 8'hAA);
        rsp_ready = 1'b1;
        tick();
        check_eq("bp_release", rsp_valid, 0);
        tick();
        check_eq("bp_dropped_rsp", rsp_cnt, r0 + 1);
        run_frame("after_bp", 8'h01, 8'h09, 8'h33, 8'h3B, 8'h06, 1, 0, 0);
        check_eq("after_bp_addr", wr_addr, 9);
        check_eq("after_bp_data", wr_data, 8'h33);

        // Reset in the middle of a frame
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h03);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("rst_mid");
        rst_n = 1'b1;
        run_frame("post_rst", 8'h01, 8'h07, 8'h11, 8'h17, 8'h06, 1, 0, 0);
        check_eq("post_rst_addr", wr_addr, 7);
        check_eq("post_rst_data", wr_data, 8'h11);

        // Reset while busy
        run_frame("start2", 8'h02, 8'h00, 8'h00, 8'h02, 8'h06, 0, 1, 0);
        check_eq("start2_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("rst_busy");
        rst_n = 1'b1;
        run_frame("post_rst2", 8'h01, 8'h3F, 8'hC3, 8'hFD, 8'h06, 1, 0, 0);
        check_eq("post_rst2_addr", wr_addr, 8'h3F);
        check_eq("post_rst2_data", wr_data, 8'hC3);
        check_eq("post_rst2_busy", busy, 0);

        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
